// File: rtl/mel_multi_monitor.sv
// Multi-channel MEL supervisor: synchronises NCH status groups, drives timed or forced
// MEL_ACK and self-timed MEL_ERROR_RESET, counts INT->ENABLE-fall time, logs changes to an OPB FIFO.
module mel_multi_monitor #(
    parameter int NCH       = 4,
    parameter int LOG_DEPTH = 16,
    parameter int TS_W      = 16,
    parameter int ERR_PULSE = 16
) (
    input  logic             SYSCLK,
    input  logic             SYS_RST_N,
    input  logic [NCH-1:0]   MEL_INT,
    input  logic [NCH-1:0]   MEL_ENABLE,
    input  logic [NCH-1:0]   MEL_ERROR,
    input  logic [3*NCH-1:0] MEL_XTRA,
    output logic [NCH-1:0]   MEL_ACK,
    output logic [NCH-1:0]   MEL_ERROR_RESET,
    input  logic [7:0]       OPB_ADDR,
    input  logic [31:0]      OPB_DI,
    input  logic             OPB_WE,
    input  logic             OPB_RE,
    output logic [31:0]      OPB_DO,
    output logic             IRQ
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_W + 11;
    localparam int PW = $clog2(ERR_PULSE + 1);

    logic [NCH-1:0]   int_s1_q, int_s2_q, en_s1_q, en_s2_q, err_s1_q, err_s2_q;
    logic [3*NCH-1:0] xtra_s1_q, xtra_s2_q;

    always_ff @(posedge SYSCLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            int_s1_q  <= '0;
            int_s2_q  <= '0;
            en_s1_q   <= '0;
            en_s2_q   <= '0;
            err_s1_q  <= '0;
            err_s2_q  <= '0;
            xtra_s1_q <= '0;
            xtra_s2_q <= '0;
        end else begin
            // NOTE: non-blocking keeps each stage sampling the previous stage's old value,
            // so this really is a two-flop chain rather than one flop.
            int_s1_q  <= MEL_INT;
            int_s2_q  <= int_s1_q;
            en_s1_q   <= MEL_ENABLE;
            en_s2_q   <= en_s1_q;
            err_s1_q  <= MEL_ERROR;
            err_s2_q  <= err_s1_q;
            xtra_s1_q <= MEL_XTRA;
            xtra_s2_q <= xtra_s1_q;
        end
    end

    logic [6:0]     state [NCH];
    logic [NCH-1:0] open_w;

    always_comb begin
        open_w = '0;
        for (int n = 0; n < NCH; n++) begin
            state[n]  = {en_s2_q[n], int_s2_q[n], err_s2_q[n], 1'b0, xtra_s2_q[3*n +: 3]};
            open_w[n] = (xtra_s2_q[3*n +: 3] == 3'b001);
        end
    end

    logic [TS_W-1:0] ts_q;
    logic            log_en_q, irq_en_q;
    logic [6:0]      last_q [NCH];
    logic [EW-1:0]   mem [LOG_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      ovf_q;
    logic [EW-1:0]   head;
    logic            full, empty;

    // Lowest-numbered channel whose state differs from its last logged value wins.
    logic           found;
    logic [3:0]     sel_ch;
    logic [6:0]     sel_state;
    logic [NCH-1:0] sel_oh;

    always_comb begin
        // NOTE: every comb output gets a default up front so no path can infer a latch.
        found     = 1'b0;
        sel_ch    = '0;
        sel_state = '0;
        sel_oh    = '0;
        for (int n = NCH - 1; n >= 0; n--) begin
            if (state[n] != last_q[n]) begin
                found     = 1'b1;
                sel_ch    = 4'(n);
                sel_state = state[n];
                sel_oh    = '0;
                sel_oh[n] = 1'b1;
            end
        end
    end

    logic [5:0]     ch_off;
    logic [1:0]     reg_sel;
    logic [NCH-1:0] ch_hit, cfg_we, err_we, cnt_we;
    logic           ctrl_we, log_clear, log_rd;
    logic           push_req, do_push, do_pop, drop;

    assign ch_off    = OPB_ADDR[7:2] - 6'd4;
    assign reg_sel   = OPB_ADDR[1:0];
    assign ctrl_we   = OPB_WE && (OPB_ADDR == 8'h00);
    assign log_clear = ctrl_we && OPB_DI[2];
    assign log_rd    = OPB_RE && (OPB_ADDR == 8'h02);
    assign full      = (count_q == CW'(LOG_DEPTH));
    assign empty     = (count_q == '0);
    assign push_req  = log_en_q && found;
    assign do_pop    = log_rd && !empty;
    assign do_push   = push_req && (!full || do_pop);
    assign drop      = push_req && full && !do_pop;
    assign head      = mem[rd_ptr_q];

    always_comb begin
        ch_hit = '0;
        cfg_we = '0;
        err_we = '0;
        cnt_we = '0;
        for (int n = 0; n < NCH; n++) begin
            ch_hit[n] = (OPB_ADDR[7:4] != 4'h0) && (ch_off == 6'(n));
            cfg_we[n] = OPB_WE && ch_hit[n] && (reg_sel == 2'd1);
            err_we[n] = OPB_WE && ch_hit[n] && (reg_sel == 2'd2) && OPB_DI[0];
            cnt_we[n] = OPB_WE && ch_hit[n] && (reg_sel == 2'd3);
        end
    end

    always_ff @(posedge SYSCLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            ts_q     <= '0;
            log_en_q <= 1'b1;
            irq_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            for (int n = 0; n < NCH; n++) last_q[n] <= 7'h7F;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (ctrl_we) begin
                log_en_q <= OPB_DI[0];
                irq_en_q <= OPB_DI[1];
            end
            // last[] tracks the state even when the entry is dropped or cleared away.
            for (int n = 0; n < NCH; n++)
                if (push_req && sel_oh[n]) last_q[n] <= sel_state;
            if (log_clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (do_push && !do_pop)      count_q <= count_q + CW'(1);
                else if (!do_push && do_pop) count_q <= count_q - CW'(1);
                if (drop && ovf_q != 8'hFF)  ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; pointers and count define which words are valid.
    always_ff @(posedge SYSCLK) begin
        if (do_push) mem[wr_ptr_q] <= {ts_q, sel_ch, sel_state};
    end

    logic [15:0]    ack_set_q [NCH];
    logic [15:0]    timer_q   [NCH];
    logic [31:0]    cnt_q     [NCH];
    logic [PW-1:0]  pulse_q   [NCH];
    logic [NCH-1:0] ack_en_q, mode_q, force_q, ack_q, cen_q;

    always_ff @(posedge SYSCLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            ack_en_q <= '1;
            mode_q   <= '0;
            force_q  <= '0;
            ack_q    <= '0;
            cen_q    <= '0;
            for (int n = 0; n < NCH; n++) begin
                ack_set_q[n] <= 16'h0010;
                timer_q[n]   <= '0;
                cnt_q[n]     <= '0;
                pulse_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (cfg_we[n]) begin
                    ack_set_q[n] <= OPB_DI[15:0];
                    ack_en_q[n]  <= OPB_DI[16];
                    mode_q[n]    <= OPB_DI[17];
                    force_q[n]   <= OPB_DI[18];
                end

                if (!open_w[n])
                    timer_q[n] <= '0;
                else if (!mode_q[n] && !(ack_en_q[n] && timer_q[n] >= ack_set_q[n])
                         && timer_q[n] != 16'hFFFF)
                    timer_q[n] <= timer_q[n] + 16'd1;

                if (mode_q[n])
                    ack_q[n] <= force_q[n];
                else if (!open_w[n])
                    ack_q[n] <= 1'b0;
                else if (ack_en_q[n] && timer_q[n] >= ack_set_q[n])
                    ack_q[n] <= 1'b1;

                // A synced INT that coincides with ENABLE low still starts the measurement.
                if (int_s2_q[n])     cen_q[n] <= 1'b1;
                else if (!en_s2_q[n]) cen_q[n] <= 1'b0;

                if (cnt_we[n])                          cnt_q[n] <= '0;
                else if (cen_q[n] && cnt_q[n] != '1)    cnt_q[n] <= cnt_q[n] + 32'd1;

                if (err_we[n])              pulse_q[n] <= PW'(ERR_PULSE);
                else if (pulse_q[n] != '0)  pulse_q[n] <= pulse_q[n] - PW'(1);
            end
        end
    end

    logic [8:0]  fill9;
    logic [7:0]  fill_b;
    logic [31:0] rd_data, do_q;
    logic        unused_di;

    assign fill9     = 9'(count_q);
    assign fill_b    = fill9[8] ? 8'hFF : fill9[7:0];
    assign unused_di = ^OPB_DI[31:19];

    always_comb begin
        rd_data = '0;
        case (OPB_ADDR)
            8'h00: rd_data = {30'b0, irq_en_q, log_en_q};
            8'h01: rd_data = {8'b0, ovf_q, fill_b, 6'b0, full, empty};
            8'h02: if (!empty) rd_data = {16'(head[EW-1 -: TS_W]), 4'b0, head[10:7], 1'b0, head[6:0]};
            8'h03: rd_data = 32'(ts_q);
            default: ;
        endcase
        for (int n = 0; n < NCH; n++) begin
            if (ch_hit[n]) begin
                case (reg_sel)
                    2'd0: rd_data = 32'(state[n]);
                    2'd1: rd_data = {13'b0, force_q[n], mode_q[n], ack_en_q[n], ack_set_q[n]};
                    2'd2: rd_data = {31'b0, pulse_q[n] != '0};
                    default: rd_data = cnt_q[n];
                endcase
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N)  do_q <= '0;
        else if (OPB_RE) do_q <= rd_data;
    end

    always_comb begin
        MEL_ERROR_RESET = '0;
        for (int n = 0; n < NCH; n++) MEL_ERROR_RESET[n] = (pulse_q[n] != '0);
    end

    assign MEL_ACK = ack_q;
    assign OPB_DO  = do_q;
    assign IRQ     = irq_en_q && !empty;

endmodule

// File: tb/tb_mel_multi_monitor.sv
// Scoreboard bench for mel_multi_monitor: stimulus queues expected OPB reads and pin probes,
// a negedge monitor pops and compares whenever a read returns or a probe is requested.
module tb_mel_multi_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mel_int = '0, mel_en = '0, mel_err = '0;
    logic [11:0] mel_xtra = '0;
    logic [3:0]  mel_ack, mel_err_rst;
    logic [7:0]  addr = '0;
    logic [31:0] di = '0, do_w;
    logic        we = 1'b0, re = 1'b0, irq;

    always #5 clk = ~clk;

    mel_multi_monitor #(.NCH(4), .LOG_DEPTH(16), .TS_W(16), .ERR_PULSE(16)) dut (
        .SYSCLK          (clk),
        .SYS_RST_N       (rst_n),
        .MEL_INT         (mel_int),
        .MEL_ENABLE      (mel_en),
        .MEL_ERROR       (mel_err),
        .MEL_XTRA        (mel_xtra),
        .MEL_ACK         (mel_ack),
        .MEL_ERROR_RESET (mel_err_rst),
        .OPB_ADDR        (addr),
        .OPB_DI          (di),
        .OPB_WE          (we),
        .OPB_RE          (re),
        .OPB_DO          (do_w),
        .IRQ             (irq)
    );

    // Cycle k is the cycle after the k-th rising edge since reset release; ts equals k there.
    int   cyc;
    logic rd_vld;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= 0;
            rd_vld <= 1'b0;
        end else begin
            cyc    <= cyc + 1;
            rd_vld <= re;
        end
    end

    logic [31:0] rd_exp[$];
    int          rd_tol[$];
    string       rd_name[$];
    logic [31:0] pin_exp[$];
    string       pin_name[$];
    int          probe_sel = 0;
    logic        probe_req = 1'b0;
    logic        drain_req = 1'b0;

    int          vectors = 0, miscompares = 0;
    logic [31:0] mon_e, mon_got, mon_diff;
    int          mon_t;
    string       mon_n;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_exp.size() == 0) begin
                $display("FAIL unexpected_read: got %h, nothing queued", do_w);
                miscompares++;
            end else begin
                mon_e = rd_exp.pop_front();
                mon_t = rd_tol.pop_front();
                mon_n = rd_name.pop_front();
                vectors++;
                mon_diff = (do_w > mon_e) ? do_w - mon_e : mon_e - do_w;
                if (mon_diff > 32'(mon_t)) begin
                    $display("FAIL %s: got %h, expected %h (tol %0d)", mon_n, do_w, mon_e, mon_t);
                    miscompares++;
                end
            end
        end
        if (probe_req) begin
            case (probe_sel)
                0:       mon_got = 32'(mel_ack);
                1:       mon_got = 32'(mel_err_rst);
                2:       mon_got = 32'(irq);
                default: mon_got = do_w;
            endcase
            mon_e = pin_exp.pop_front();
            mon_n = pin_name.pop_front();
            vectors++;
            if (mon_got !== mon_e) begin
                $display("FAIL %s: got %h, expected %h", mon_n, mon_got, mon_e);
                miscompares++;
            end
        end
        if (drain_req && (rd_exp.size() != 0 || pin_exp.size() != 0)) begin
            $display("FAIL drain: %0d reads and %0d probes outstanding, expected 0",
                     rd_exp.size(), pin_exp.size());
            miscompares++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm, input int tol = 0);
        addr = a;
        re   = 1'b1;
        rd_exp.push_back(e);
        rd_tol.push_back(tol);
        rd_name.push_back(nm);
        tick(1);
        re = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = a;
        di   = d;
        we   = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    // sel: 0 MEL_ACK, 1 MEL_ERROR_RESET, 2 IRQ, 3 OPB_DO; sampled in the current cycle.
    task automatic probe(input int sel, input logic [31:0] e, input string nm);
        probe_sel = sel;
        probe_req = 1'b1;
        pin_exp.push_back(e);
        pin_name.push_back(nm);
        tick(1);
        probe_req = 1'b0;
    endtask

    function automatic logic [31:0] tsw(input int t);
        return {16'(t), 16'h0000};
    endfunction

    int c;
    int ck[20];

    initial begin
        tick(2);
        probe(3, 0, "rst_opb_do");
        probe(0, 0, "rst_ack");
        probe(1, 0, "rst_err_reset");
        probe(2, 0, "rst_irq");
        rst_n = 1'b1;
        tick(6);

        // Start-up: one entry per channel, state 0, ts = channel index.
        rd(8'h01, 32'h0000_0400, "status_startup");
        probe(2, 0, "irq_masked");
        wr(8'h00, 32'h3);
        probe(2, 1, "irq_enabled");
        for (int k = 0; k < 4; k++)
            rd(8'h02, tsw(k) | 32'(k << 8), $sformatf("log_startup_%0d", k));
        probe(2, 0, "irq_empty");
        rd(8'h01, 32'h1, "status_empty");
        rd(8'h02, 32'h0, "log_read_empty");
        rd(8'h00, 32'h3, "ctrl_readback");

        // Ch1 and ch3 change together: ch1 first, ch3 one cycle later.
        mel_int = 4'b1010;
        c = cyc;
        tick(5);
        rd(8'h02, tsw(c + 2) | 32'h120, "log_ch1_rise");
        rd(8'h02, tsw(c + 3) | 32'h320, "log_ch3_rise");
        mel_int = 4'b0000;
        c = cyc;
        tick(5);
        rd(8'h02, tsw(c + 2) | 32'h100, "log_ch1_fall");
        rd(8'h02, tsw(c + 3) | 32'h300, "log_ch3_fall");

        // Ch2 timed ACK with ack_set = 5.
        wr(8'h19, 32'h0001_0005);
        rd(8'h19, 32'h0001_0005, "ack_cfg_readback");
        mel_xtra[8:6] = 3'b001;
        for (int j = 0; j <= 10; j++)
            probe(0, (j >= 8) ? 32'h4 : 32'h0, $sformatf("ack_rise_c%0d", j));
        mel_xtra[8:6] = 3'b000;
        for (int j = 0; j <= 4; j++)
            probe(0, (j >= 3) ? 32'h0 : 32'h4, $sformatf("ack_fall_c%0d", j));
        wr(8'h19, 32'h0000_0005);
        mel_xtra[8:6] = 3'b001;
        for (int j = 0; j < 15; j++)
            probe(0, 32'h0, $sformatf("ack_disabled_c%0d", j));
        mel_xtra[8:6] = 3'b000;
        tick(4);
        wr(8'h19, 32'h0006_0005);
        tick(1);
        probe(0, 32'h4, "ack_forced");
        wr(8'h19, 32'h0001_0010);
        tick(1);
        probe(0, 32'h0, "ack_unforced");

        wr(8'h00, 32'h7);
        rd(8'h01, 32'h1, "status_cleared");
        rd(8'h00, 32'h3, "ctrl_clear_reads0");
        rd(8'h05, 32'h0, "unmapped_05");
        rd(8'h20, 32'h0, "unmapped_ch4");

        // 20 ch0 INT toggles into a 16-deep FIFO.
        for (int k = 0; k < 20; k++) begin
            mel_int[0] = ~mel_int[0];
            ck[k] = cyc;
            tick(2);
        end
        tick(4);
        rd(8'h01, 32'h0004_1002, "status_full");
        rd(8'h02, tsw(ck[0] + 2) | 32'h20, "log_ovf_0");
        rd(8'h01, 32'h0004_0F00, "status_after_pop");
        for (int k = 1; k < 16; k++)
            rd(8'h02, tsw(ck[k] + 2) | ((k % 2 == 0) ? 32'h20 : 32'h0), $sformatf("log_ovf_%0d", k));
        rd(8'h01, 32'h0004_0001, "status_drained");
        wr(8'h00, 32'h7);
        rd(8'h01, 32'h1, "status_ovf_cleared");

        // Ch0 duration: INT pulse, ENABLE falls 100 cycles after the pulse starts.
        mel_en[0] = 1'b1;
        tick(4);
        rd(8'h10, 32'h40, "state_ch0");
        wr(8'h13, 32'h0);
        rd(8'h13, 32'h0, "cntr_cleared");
        mel_int[0] = 1'b1;
        tick(2);
        mel_int[0] = 1'b0;
        tick(98);
        mel_en[0] = 1'b0;
        tick(10);
        rd(8'h13, 32'd100, "cntr_duration", 2);
        wr(8'h13, 32'h0);
        rd(8'h13, 32'h0, "cntr_cleared_again");

        // Ch1 error-reset pulse, then a restart at pulse cycle 10.
        wr(8'h16, 32'h1);
        for (int j = 0; j < 16; j++)
            probe(1, 32'h2, $sformatf("err_pulse_c%0d", j));
        probe(1, 32'h0, "err_pulse_end");
        rd(8'h16, 32'h0, "err_rst_idle");
        wr(8'h16, 32'h1);
        for (int j = 0; j < 9; j++)
            probe(1, 32'h2, $sformatf("err_restart_pre_c%0d", j));
        wr(8'h16, 32'h1);
        for (int j = 0; j < 16; j++)
            probe(1, 32'h2, $sformatf("err_restart_post_c%0d", j));
        probe(1, 32'h0, "err_restart_end");

        // Reset during a pulse clears outputs without waiting for a clock.
        wr(8'h16, 32'h1);
        rd(8'h16, 32'h1, "err_rst_active");
        tick(2);
        probe(1, 32'h2, "err_pre_reset");
        rst_n = 1'b0;
        probe(1, 32'h0, "err_async_reset");
        probe(3, 32'h0, "opb_do_async_reset");
        probe(2, 32'h0, "irq_async_reset");
        rst_n = 1'b1;
        tick(3);

        drain_req = 1'b1;
        tick(1);
        drain_req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mel_multi_monitor.md
# mel_multi_monitor

Parametrised multi-channel MEL supervisor: replaces the single-channel MEL block in the ATE controller FPGA. Synchronises NCH MEL status groups, drives a timed or software-forced MEL_ACK and a self-timed MEL_ERROR_RESET pulse per channel, measures INT-to-ENABLE-fall duration per channel, and records every state change into a shared timestamped event FIFO that software reads and pops over the OPB register port.

## Interface
Parameters:
- NCH, 4, channel count (1..16)
- LOG_DEPTH, 16, event FIFO depth (power of 2, 4..256)
- TS_W, 16, timestamp width (1..16)
- ERR_PULSE, 16, MEL_ERROR_RESET pulse length in cycles (≥1)

Ports:
- SYSCLK  in  1  single clock for all logic
- SYS_RST_N  in  1  reset, asynchronous, active-low
- MEL_INT  in  NCH  per-channel interrupt (async)
- MEL_ENABLE  in  NCH  per-channel enable (async)
- MEL_ERROR  in  NCH  per-channel error (async)
- MEL_XTRA  in  3*NCH  per-channel controller state, ch n at [3n+2:3n] (async)
- MEL_ACK  out  NCH  acknowledge
- MEL_ERROR_RESET  out  NCH  error-reset pulse
- OPB_ADDR  in  8  word address
- OPB_DI  in  32  write data
- OPB_WE  in  1  write strobe, one cycle per access
- OPB_RE  in  1  read strobe, one cycle per access
- OPB_DO  out  32  registered read data
- IRQ  out  1  level interrupt: irq_en and FIFO non-empty

## Operation
- All MEL inputs pass a 2-flop synchroniser. Channel state S[n] = {ENABLE, INT, ERROR, 1'b0, XTRA[2:0]} (7 bits) from synchronised values.
- Logging: per-channel last[n] (reset 7'h7F). Each cycle, if log_en, lowest n with S[n] != last[n] is selected: last[n] <= S[n], push {ts, n, S[n]}. One push per cycle; other mismatching channels are serviced on later cycles; intermediate states of a channel changing again before service are not logged.
- FIFO full on push: entry dropped, last[n] still updated, ovf_cnt (8-bit, saturating) increments. Push and pop in same cycle both succeed, including when full.
- log_clear: empties FIFO, zeroes ovf_cnt; wins over a same-cycle push/pop. last[] unchanged.
- ts: free-running TS_W-bit counter, wraps to 0.
- ACK per channel: open = (XTRA == 3'h1). Not open: timer <= 0, MEL_ACK <= 0. Open, mode 0: if ack_en and timer >= ack_set then MEL_ACK <= 1, else timer increments (saturating at 16'hFFFF). Mode 1: MEL_ACK <= force_val regardless of XTRA.
- Duration counter per channel: cen set on synced INT=1, cleared on synced ENABLE=0 (INT wins); 32-bit cnt increments while cen, saturates at 32'hFFFFFFFF; register write clears it (clear wins over increment).
- ERROR_RESET: writing bit0=1 loads pulse counter with ERR_PULSE; output high while counter non-zero; rewrite during pulse restarts it.
- Register map (word addresses; unmapped reads return 0, unmapped writes ignored):
  - 0x00 CTRL rw: [0] log_en (reset 1), [1] irq_en (reset 0), [2] log_clear (write-1 action, reads 0)
  - 0x01 STATUS ro: [0] empty, [1] full, [15:8] fill count, [23:16] ovf_cnt
  - 0x02 LOG ro: [31:16] ts zero-extended, [11:8] channel, [6:0] state; read pops; read when empty returns 0, no pop
  - 0x03 TS ro: current ts
  - 0x10+4n+0 STATE ro: S[n]
  - 0x10+4n+1 ACK_CFG rw: [15:0] ack_set (reset 16'h10), [16] ack_en (reset 1), [17] mode (reset 0), [18] force_val (reset 0)
  - 0x10+4n+2 ERR_RST: write [0]=1 starts pulse; read [0] = pulse active
  - 0x10+4n+3 CNTR: read cnt; any write clears

## Timing
- Reset: MEL_ACK 0, MEL_ERROR_RESET 0, OPB_DO 0, IRQ 0, FIFO empty, ts 0, all counters 0.
- Input pin to S[n]: 2 cycles. S change to FIFO entry visible (STATUS.empty=0, IRQ=1): 1 further cycle if channel wins arbitration.
- OPB_DO valid the cycle after OPB_RE, held until next OPB_RE; LOG pop takes effect on the OPB_RE edge.
- ACK: with ack_set=K, MEL_ACK rises K+1 cycles after first cycle synced XTRA==1; falls 1 cycle after synced XTRA leaves 1.
- ERROR_RESET high exactly ERR_PULSE cycles, starting the cycle after the write.
- Writes take effect on the OPB_WE edge.

## Test plan
- Reset release, all inputs low -> first cycles log one entry per channel 0..NCH-1 in order (state 7'h00), STATUS count = NCH, IRQ=0 until irq_en written.
- Ch2 XTRA=1, ack_set=5, mode 0 -> MEL_ACK[2] rises 6 cycles after synced open; XTRA=0 -> falls next cycle; ack_en=0 -> never rises.
- Toggle ch0 INT 20 times with LOG_DEPTH=16, no reads -> full=1, 16 entries kept (oldest first), ovf_cnt=4; one LOG read -> count 15.
- Ch1 and ch3 change same cycle -> ch1 entry then ch3 entry, timestamps differ by 1.
- Ch0 INT pulse, ENABLE falls 100 cycles later -> CNTR ≈100 (±2 sync); write CNTR -> 0.
- Write ERR_RST ch1 with ERR_PULSE=16 -> MEL_ERROR_RESET[1] high 16 cycles; rewrite at cycle 10 -> high 26 total; assert SYS_RST_N low mid-pulse -> output 0 immediately.
